im_boot_loader: RTL

- Byte-stream loader that fills the writable instruction memory before the single-cycle CPU runs.
- Receives a framed stream over a valid/ready byte interface: 16-bit word count, big-endian 32-bit instruction words, then a checksum byte.
- Assembles each word and drives a one-cycle write strobe to the IM write port at consecutive word addresses starting at 0.
- Holds the CPU in reset (cpu_hold) until a complete, checksum-verified image has been written.

---
 rtl/im_boot_loader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/im_boot_loader.sv
// Byte-stream loader for the writable instruction memory: length header, big-endian words,
// trailing checksum byte. Holds the CPU in reset until a verified image has been written.
module im_boot_loader #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DEPTH  = 128
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic              i_in_valid,
    input  logic [7:0]        i_in_data,
    output logic              o_in_ready,
    output logic              o_im_we,
    output logic [ADDR_W-1:0] o_im_addr,
    output logic [31:0]       o_im_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_cpu_hold
);

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    state_e              r_state;
    state_e              w_next;
    logic [15:0]         r_len;
    logic [1:0]          r_byte_cnt;
    logic [ADDR_W:0]     r_word_cnt;
    logic [7:0]          r_csum;
    logic [23:0]         r_asm;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;

    logic                w_accept;
    logic [15:0]         w_len;
    logic                w_len_bad;
    logic                w_last_word;
    logic [7:0]          w_csum_sum;
    logic                w_enter_len;

    assign w_accept    = i_in_valid & o_in_ready;
    assign w_len       = {r_len[15:8], i_in_data};
    assign w_len_bad   = (w_len == 16'd0) || (w_len > 16'(DEPTH));
    // Word counter is one bit wider than the address so len == DEPTH does not wrap.
    assign w_last_word = (16'(r_word_cnt) == (r_len - 16'd1));
    assign w_csum_sum  = r_csum + i_in_data;
    assign w_enter_len = (w_next == StLenHi) && (r_state != StLenHi);

    always_comb begin
        w_next     = r_state;
        o_in_ready = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_err      = 1'b0;
        o_cpu_hold = 1'b1;
        case (r_state)
            StIdle: begin
                if (i_start) w_next = StLenHi;
            end
            StLenHi: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b1;
                if (w_accept) w_next = StLenLo;
            end
            StLenLo: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b1;
                if (w_accept) w_next = w_len_bad ? StErr : StData;
            end
            StData: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b1;
                if (w_accept && (r_byte_cnt == 2'd3) && w_last_word) w_next = StCsum;
            end
            StCsum: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b1;
                if (w_accept) w_next = (w_csum_sum == 8'd0) ? StDone : StErr;
            end
            StDone: begin
                o_done     = 1'b1;
                o_cpu_hold = 1'b0;
                if (i_start) w_next = StLenHi;
            end
            StErr: begin
                o_err = 1'b1;
                if (i_start) w_next = StLenHi;
            end
            default: w_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state    <= StIdle;
            r_len      <= 16'd0;
            r_byte_cnt <= 2'd0;
            r_word_cnt <= '0;
            r_csum     <= 8'd0;
            r_asm      <= 24'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
        end else begin
            r_state <= w_next;
            r_we    <= 1'b0;
            if (w_enter_len) begin
                r_csum <= 8'd0;
            end else if (w_accept) begin
                r_csum <= w_csum_sum;
            end
            case (r_state)
                StLenHi: begin
                    if (w_accept) r_len[15:8] <= i_in_data;
                end
                StLenLo: begin
                    if (w_accept) begin
                        r_len[7:0] <= i_in_data;
                        r_byte_cnt <= 2'd0;
                        r_word_cnt <= '0;
                    end
                end
                StData: begin
                    if (w_accept) begin
                        r_asm      <= {r_asm[15:0], i_in_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_we       <= 1'b1;
                            r_addr     <= r_word_cnt[ADDR_W-1:0];
                            r_wdata    <= {r_asm, i_in_data};
                            r_word_cnt <= r_word_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_im_we    = r_we;
    assign o_im_addr  = r_addr;
    assign o_im_wdata = r_wdata;

endmodule
